// File: rtl/slv_wrp_pkg.sv
// Shared codes for the Core-B Lite slave wrapper: bus transfer modes, sizes,
// slave FSM states and the size/alignment legality check.
package slv_wrp_pkg;

    typedef enum logic [2:0] {
        MOD_IDLE   = 3'd0,
        MOD_BUSY   = 3'd1,
        MOD_NONSEQ = 3'd2,
        MOD_SEQ    = 3'd3
    } mod_e;

    localparam logic [2:0] SZ_BYTE = 3'd0;
    localparam logic [2:0] SZ_HALF = 3'd1;
    localparam logic [2:0] SZ_WORD = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slv_st_e;

    // 1 when the size code is illegal or the address is not naturally aligned
    function automatic logic sz_addr_err(input logic [2:0] sz, input logic [1:0] a);
        logic err;
        case (sz)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = a[0];
            SZ_WORD: err = (a != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/slv_wrp_fsm.sv
// Slave wrapper control decode: next state, bus handshake outputs, core
// request and the address-phase latch enable.
module slv_wrp_fsm
    import slv_wrp_pkg::*;
(
    input  slv_st_e state,
    input  logic    sel_act,
    input  logic    addr_err,
    input  logic    core_done,
    input  logic    core_err,
    input  logic    wd_expire,
    output slv_st_e state_nxt,
    output logic    ms_rdy,
    output logic    ms_err,
    output logic    core_req,
    output logic    lat_en
);

    // Next-state and output decode; an accept may only happen while MsRDY=1
    always_comb begin
        state_nxt = state;
        ms_rdy    = 1'b1;
        ms_err    = 1'b0;
        core_req  = 1'b0;
        lat_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sel_act) begin
                    lat_en    = 1'b1;
                    state_nxt = addr_err ? ST_ERR1 : ST_DATA;
                end
            end
            ST_DATA: begin
                core_req = 1'b1;
                ms_rdy   = core_done & ~core_err;
                if (core_done) begin
                    if (core_err) begin
                        state_nxt = ST_ERR1;
                    end else if (sel_act) begin
                        lat_en    = 1'b1;
                        state_nxt = addr_err ? ST_ERR1 : ST_DATA;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (wd_expire) begin
                    state_nxt = ST_ERR1;
                end
            end
            ST_ERR1: begin
                ms_rdy    = 1'b0;
                ms_err    = 1'b1;
                state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                ms_err    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/slv_wrp.sv
// Core-B Lite slave wrapper: turns pipelined address/data-phase bus
// transfers into a request/wait core interface, with a two-cycle error
// response and a wait-state watchdog.
module slv_wrp
    import slv_wrp_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 39,
    parameter int TIMEOUT = 15
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          MxSEL,
    input  logic          MxWT,
    input  logic [2:0]    MxSZ,
    input  logic [3:0]    MxRB,
    input  logic [2:0]    MxMOD,
    input  logic [31:0]   MxADDR,
    input  logic [DW-1:0] MxWDT,
    output logic          MsRDY,
    output logic          MsERR,
    output logic [DW-1:0] MsRDT,
    output logic          SCx_REQ,
    output logic          SCx_WT,
    output logic [2:0]    SCx_SZ,
    output logic [AW-1:0] SCx_ADDR,
    output logic [DW-1:0] SCx_WDT,
    input  logic [DW-1:0] SCx_RDT,
    input  logic          SCx_nWAIT,
    input  logic          SCx_ERR
);

    // A width of at least one keeps the counter legal when the watchdog is off
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    slv_st_e       state_q;
    slv_st_e       state_d;
    logic          wt_q;
    logic [2:0]    sz_q;
    logic [AW-1:0] addr_q;
    logic [3:0]    rb_q;
    logic [DW-1:0] rdt_q;
    logic [CW-1:0] wd_cnt_q;
    logic          sel_act;
    logic          addr_err;
    logic          wd_expire;
    logic          rd_done;
    logic          lat_en;
    logic          core_req;
    logic          unused_sig;

    assign sel_act   = MxSEL & ((MxMOD == MOD_NONSEQ) | (MxMOD == MOD_SEQ));
    assign addr_err  = sz_addr_err(MxSZ, MxADDR[1:0]);
    assign wd_expire = (TIMEOUT != 0) && (state_q == ST_DATA) && !SCx_nWAIT
                       && (wd_cnt_q == CW'(TIMEOUT));
    assign rd_done   = (state_q == ST_DATA) & SCx_nWAIT & ~SCx_ERR & ~wt_q;

    slv_wrp_fsm u_fsm (
        .state     (state_q),
        .sel_act   (sel_act),
        .addr_err  (addr_err),
        .core_done (SCx_nWAIT),
        .core_err  (SCx_ERR),
        .wd_expire (wd_expire),
        .state_nxt (state_d),
        .ms_rdy    (MsRDY),
        .ms_err    (MsERR),
        .core_req  (core_req),
        .lat_en    (lat_en)
    );

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Address-phase capture on every accepted transfer
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wt_q   <= 1'b0;
            sz_q   <= '0;
            addr_q <= '0;
            rb_q   <= '0;
        end else if (lat_en) begin
            wt_q   <= MxWT;
            sz_q   <= MxSZ;
            addr_q <= MxADDR[AW-1:0];
            rb_q   <= MxRB;
        end
    end

    // Watchdog: counts consecutive wait cycles of one data phase
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                                              wd_cnt_q <= '0;
        else if (state_q == ST_DATA && !SCx_nWAIT && !wd_expire) wd_cnt_q <= wd_cnt_q + CW'(1);
        else                                                    wd_cnt_q <= '0;
    end

    // Read-data hold: keeps the last successfully completed read value
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)        rdt_q <= '0;
        else if (rd_done) rdt_q <= SCx_RDT;
    end

    assign MsRDT    = rd_done ? SCx_RDT : rdt_q;
    assign SCx_REQ  = core_req;
    assign SCx_WT   = wt_q;
    assign SCx_SZ   = sz_q;
    assign SCx_ADDR = addr_q;
    assign SCx_WDT  = MxWDT;

    // Upper address bits and remaining-beat count are not needed by the core
    assign unused_sig = ^{MxADDR[31:AW], rb_q};

endmodule

// File: tb/tb_slv_wrp.sv
// Directed self-checking bench for the slave wrapper.
module tb_slv_wrp;

    localparam int AW = 16;
    localparam int DW = 39;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          MxSEL;
    logic          MxWT;
    logic [2:0]    MxSZ;
    logic [3:0]    MxRB;
    logic [2:0]    MxMOD;
    logic [31:0]   MxADDR;
    logic [DW-1:0] MxWDT;
    logic          MsRDY;
    logic          MsERR;
    logic [DW-1:0] MsRDT;
    logic          SCx_REQ;
    logic          SCx_WT;
    logic [2:0]    SCx_SZ;
    logic [AW-1:0] SCx_ADDR;
    logic [DW-1:0] SCx_WDT;
    logic [DW-1:0] SCx_RDT;
    logic          SCx_nWAIT;
    logic          SCx_ERR;

    int total = 0;
    int bad   = 0;

    localparam logic [DW-1:0] RD_VAL = 39'h0A5A5A5A5;

    slv_wrp #(.AW(AW), .DW(DW), .TIMEOUT(15)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .MxSEL     (MxSEL),
        .MxWT      (MxWT),
        .MxSZ      (MxSZ),
        .MxRB      (MxRB),
        .MxMOD     (MxMOD),
        .MxADDR    (MxADDR),
        .MxWDT     (MxWDT),
        .MsRDY     (MsRDY),
        .MsERR     (MsERR),
        .MsRDT     (MsRDT),
        .SCx_REQ   (SCx_REQ),
        .SCx_WT    (SCx_WT),
        .SCx_SZ    (SCx_SZ),
        .SCx_ADDR  (SCx_ADDR),
        .SCx_WDT   (SCx_WDT),
        .SCx_RDT   (SCx_RDT),
        .SCx_nWAIT (SCx_nWAIT),
        .SCx_ERR   (SCx_ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL global_timeout bench did not finish");
        $fatal(1, "bench timeout");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_idle();
        MxSEL  = 1'b0;
        MxWT   = 1'b0;
        MxSZ   = 3'd0;
        MxRB   = 4'd0;
        MxMOD  = 3'd0;
        MxADDR = 32'h0;
    endtask

    task automatic addr_phase(input logic wt, input logic [2:0] sz, input logic [2:0] md,
                              input logic [31:0] a, input logic [3:0] rb);
        MxSEL  = 1'b1;
        MxWT   = wt;
        MxSZ   = sz;
        MxMOD  = md;
        MxADDR = a;
        MxRB   = rb;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        bus_idle();
        MxWDT = '0; SCx_RDT = '0; SCx_nWAIT = 1'b1; SCx_ERR = 1'b0;
        #12;
        total++; if (MsRDY !== 1'b1) begin bad++; $display("FAIL rst_rdy got=%b exp=1", MsRDY); end
        total++; if (MsERR !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", MsERR); end
        total++; if (MsRDT !== '0) begin bad++; $display("FAIL rst_rdt got=%h exp=0", MsRDT); end
        total++; if (SCx_REQ !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", SCx_REQ); end
        total++; if (SCx_WT !== 1'b0) begin bad++; $display("FAIL rst_wt got=%b exp=0", SCx_WT); end
        total++; if (SCx_SZ !== 3'd0) begin bad++; $display("FAIL rst_sz got=%0d exp=0", SCx_SZ); end
        total++; if (SCx_ADDR !== 16'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", SCx_ADDR); end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_write();
        step();
        addr_phase(1'b1, 3'd2, 3'd2, 32'h0000_0104, 4'd0);
        SCx_nWAIT = 1'b1;
        #1;
        total++; if (MsRDY !== 1'b1) begin bad++; $display("FAIL wr_addr_rdy got=%b exp=1", MsRDY); end
        step();
        bus_idle();
        MxWDT = 39'h12345678;
        #1;
        total++; if (SCx_REQ !== 1'b1) begin bad++; $display("FAIL wr_req got=%b exp=1", SCx_REQ); end
        total++; if (SCx_WT !== 1'b1) begin bad++; $display("FAIL wr_wt got=%b exp=1", SCx_WT); end
        total++; if (SCx_ADDR !== 16'h0104) begin bad++; $display("FAIL wr_addr got=%h exp=0104", SCx_ADDR); end
        total++; if (SCx_SZ !== 3'd2) begin bad++; $display("FAIL wr_sz got=%0d exp=2", SCx_SZ); end
        total++; if (SCx_WDT !== 39'h12345678) begin bad++; $display("FAIL wr_wdt got=%h exp=12345678", SCx_WDT); end
        total++; if (MsRDY !== 1'b1) begin bad++; $display("FAIL wr_rdy got=%b exp=1", MsRDY); end
        total++; if (MsERR !== 1'b0) begin bad++; $display("FAIL wr_err got=%b exp=0", MsERR); end
        step();
        #1;
        total++; if (SCx_REQ !== 1'b0) begin bad++; $display("FAIL wr_done_req got=%b exp=0", SCx_REQ); end
    endtask

    task automatic test_read_wait();
        step();
        addr_phase(1'b0, 3'd2, 3'd2, 32'h0000_0200, 4'd0);
        step();
        bus_idle();
        SCx_nWAIT = 1'b0;
        #1;
        total++; if (MsRDY !== 1'b0) begin bad++; $display("FAIL rd_w1_rdy got=%b exp=0", MsRDY); end
        total++; if (SCx_REQ !== 1'b1) begin bad++; $display("FAIL rd_w1_req got=%b exp=1", SCx_REQ); end
        step();
        #1;
        total++; if (MsRDY !== 1'b0) begin bad++; $display("FAIL rd_w2_rdy got=%b exp=0", MsRDY); end
        total++; if (SCx_REQ !== 1'b1) begin bad++; $display("FAIL rd_w2_req got=%b exp=1", SCx_REQ); end
        step();
        SCx_nWAIT = 1'b1;
        SCx_RDT   = RD_VAL;
        #1;
        total++; if (MsRDY !== 1'b1) begin bad++; $display("FAIL rd_done_rdy got=%b exp=1", MsRDY); end
        total++; if (MsRDT !== RD_VAL) begin bad++; $display("FAIL rd_done_rdt got=%h exp=%h", MsRDT, RD_VAL); end
        step();
        SCx_RDT = '0;
        #1;
        total++; if (MsRDT !== RD_VAL) begin bad++; $display("FAIL rd_hold_rdt got=%h exp=%h", MsRDT, RD_VAL); end
        total++; if (SCx_REQ !== 1'b0) begin bad++; $display("FAIL rd_hold_req got=%b exp=0", SCx_REQ); end
    endtask

    task automatic test_back_to_back();
        step();
        addr_phase(1'b1, 3'd2, 3'd2, 32'h0000_0300, 4'd3);
        for (int unsigned i = 1; i <= 4; i++) begin
            step();
            if (i < 4) addr_phase(1'b1, 3'd2, 3'd3, 32'h0000_0300 + 32'(4 * i), 4'(3 - i));
            else       bus_idle();
            #1;
            total++; if (SCx_REQ !== 1'b1) begin bad++; $display("FAIL burst_req beat=%0d got=%b exp=1", i, SCx_REQ); end
            total++; if (SCx_ADDR !== 16'(16'h0300 + 4 * (i - 1))) begin bad++; $display("FAIL burst_addr beat=%0d got=%h exp=%h", i, SCx_ADDR, 16'(16'h0300 + 4 * (i - 1))); end
            total++; if (MsRDY !== 1'b1) begin bad++; $display("FAIL burst_rdy beat=%0d got=%b exp=1", i, MsRDY); end
        end
        step();
        #1;
        total++; if (SCx_REQ !== 1'b0) begin bad++; $display("FAIL burst_end_req got=%b exp=0", SCx_REQ); end
    endtask

    task automatic test_misaligned();
        step();
        addr_phase(1'b1, 3'd2, 3'd2, 32'h0000_0102, 4'd0);
        step();
        bus_idle();
        #1;
        total++; if (SCx_REQ !== 1'b0) begin bad++; $display("FAIL mis_e1_req got=%b exp=0", SCx_REQ); end
        total++; if (MsRDY !== 1'b0) begin bad++; $display("FAIL mis_e1_rdy got=%b exp=0", MsRDY); end
        total++; if (MsERR !== 1'b1) begin bad++; $display("FAIL mis_e1_err got=%b exp=1", MsERR); end
        step();
        // a legal transfer offered during the second error cycle must be dropped
        addr_phase(1'b1, 3'd2, 3'd2, 32'h0000_0500, 4'd0);
        #1;
        total++; if (MsRDY !== 1'b1) begin bad++; $display("FAIL mis_e2_rdy got=%b exp=1", MsRDY); end
        total++; if (MsERR !== 1'b1) begin bad++; $display("FAIL mis_e2_err got=%b exp=1", MsERR); end
        total++; if (SCx_REQ !== 1'b0) begin bad++; $display("FAIL mis_e2_req got=%b exp=0", SCx_REQ); end
        step();
        bus_idle();
        #1;
        total++; if (MsERR !== 1'b0) begin bad++; $display("FAIL mis_idle_err got=%b exp=0", MsERR); end
        total++; if (MsRDY !== 1'b1) begin bad++; $display("FAIL mis_idle_rdy got=%b exp=1", MsRDY); end
        total++; if (SCx_REQ !== 1'b0) begin bad++; $display("FAIL mis_ignored_req got=%b exp=0", SCx_REQ); end
        // half-word at an odd address is also rejected
        step();
        addr_phase(1'b0, 3'd1, 3'd2, 32'h0000_0011, 4'd0);
        step();
        bus_idle();
        #1;
        total++; if (MsERR !== 1'b1 || SCx_REQ !== 1'b0) begin bad++; $display("FAIL mis_half err=%b req=%b exp err=1 req=0", MsERR, SCx_REQ); end
        step();
        step();
    endtask

    task automatic test_timeout();
        int req_cycles;
        step();
        addr_phase(1'b0, 3'd2, 3'd2, 32'h0000_0400, 4'd0);
        step();
        bus_idle();
        SCx_nWAIT = 1'b0;
        #1;
        req_cycles = 0;
        for (int i = 0; i < 20 && SCx_REQ === 1'b1; i++) begin
            req_cycles++;
            step();
            #1;
        end
        total++; if (req_cycles !== 16) begin bad++; $display("FAIL wd_req_cycles got=%0d exp=16", req_cycles); end
        total++; if (MsRDY !== 1'b0 || MsERR !== 1'b1) begin bad++; $display("FAIL wd_e1 rdy=%b err=%b exp rdy=0 err=1", MsRDY, MsERR); end
        step();
        SCx_nWAIT = 1'b1;
        #1;
        total++; if (MsRDY !== 1'b1 || MsERR !== 1'b1) begin bad++; $display("FAIL wd_e2 rdy=%b err=%b exp rdy=1 err=1", MsRDY, MsERR); end
        step();
        #1;
        total++; if (MsERR !== 1'b0 || SCx_REQ !== 1'b0) begin bad++; $display("FAIL wd_idle err=%b req=%b exp 0 0", MsERR, SCx_REQ); end
    endtask

    task automatic test_core_err();
        step();
        addr_phase(1'b0, 3'd0, 3'd2, 32'h0000_0601, 4'd0);
        step();
        bus_idle();
        SCx_nWAIT = 1'b1;
        SCx_ERR   = 1'b1;
        SCx_RDT   = 39'h7F_FFFF_FFFF;
        #1;
        total++; if (MsRDY !== 1'b0) begin bad++; $display("FAIL cerr_rdy got=%b exp=0", MsRDY); end
        total++; if (SCx_REQ !== 1'b1) begin bad++; $display("FAIL cerr_req got=%b exp=1", SCx_REQ); end
        total++; if (MsRDT !== RD_VAL) begin bad++; $display("FAIL cerr_rdt got=%h exp=%h", MsRDT, RD_VAL); end
        step();
        SCx_ERR = 1'b0;
        #1;
        total++; if (MsRDY !== 1'b0 || MsERR !== 1'b1 || SCx_REQ !== 1'b0) begin bad++; $display("FAIL cerr_e1 rdy=%b err=%b req=%b exp 0 1 0", MsRDY, MsERR, SCx_REQ); end
        step();
        #1;
        total++; if (MsRDY !== 1'b1 || MsERR !== 1'b1) begin bad++; $display("FAIL cerr_e2 rdy=%b err=%b exp 1 1", MsRDY, MsERR); end
        step();
        SCx_RDT = '0;
        #1;
        total++; if (MsERR !== 1'b0 || MsRDT !== RD_VAL) begin bad++; $display("FAIL cerr_idle err=%b rdt=%h exp err=0 rdt=%h", MsERR, MsRDT, RD_VAL); end
    endtask

    task automatic test_reset_mid();
        step();
        addr_phase(1'b0, 3'd2, 3'd2, 32'h0000_0700, 4'd0);
        step();
        bus_idle();
        SCx_nWAIT = 1'b0;
        #1;
        total++; if (SCx_REQ !== 1'b1) begin bad++; $display("FAIL rm_pre_req got=%b exp=1", SCx_REQ); end
        nRST = 1'b0;
        #1;
        total++; if (SCx_REQ !== 1'b0) begin bad++; $display("FAIL rm_req got=%b exp=0", SCx_REQ); end
        total++; if (MsRDY !== 1'b1) begin bad++; $display("FAIL rm_rdy got=%b exp=1", MsRDY); end
        total++; if (MsRDT !== '0) begin bad++; $display("FAIL rm_rdt got=%h exp=0", MsRDT); end
        total++; if (SCx_ADDR !== 16'h0) begin bad++; $display("FAIL rm_addr got=%h exp=0", SCx_ADDR); end
        @(negedge CLK);
        nRST = 1'b1;
        SCx_nWAIT = 1'b1;
        step();
        addr_phase(1'b1, 3'd1, 3'd2, 32'h0000_0008, 4'd0);
        step();
        bus_idle();
        #1;
        total++; if (SCx_REQ !== 1'b1 || SCx_ADDR !== 16'h0008 || SCx_SZ !== 3'd1) begin bad++; $display("FAIL rm_next req=%b addr=%h sz=%0d exp 1 0008 1", SCx_REQ, SCx_ADDR, SCx_SZ); end
        total++; if (MsRDY !== 1'b1 || MsERR !== 1'b0) begin bad++; $display("FAIL rm_next_rdy rdy=%b err=%b exp 1 0", MsRDY, MsERR); end
        step();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_back_to_back();
        test_misaligned();
        test_timeout();
        test_core_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
